// File: rtl/wn_phase_compensation_pkg.sv
// Shared types, constants and round/saturate helpers for the phase compensation chain.
package wn_phase_compensation_pkg;

  localparam int DATA_W      = 16;
  localparam int FRAC_W      = 15;
  localparam int PROD_W      = 2 * DATA_W;
  localparam int ACC_W       = PROD_W + 1;
  localparam int SH_W        = ACC_W + 1 - FRAC_W;
  localparam int ROT_LATENCY = 3;

  localparam logic signed [DATA_W-1:0] Q15_ONE = 16'sh7FFF;
  localparam logic signed [ACC_W:0] RND_BIAS =
    {{(ACC_W + 1 - FRAC_W){1'b0}}, 1'b1, {(FRAC_W - 1){1'b0}}};

  typedef struct packed {
    logic signed [15:0] q;
    logic signed [15:0] i;
  } iq_sample_t;

  typedef struct packed {
    logic signed [15:0] sin;
    logic signed [15:0] cos;
  } phase_word_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ROTATE = 1'b1
  } rot_state_t;

  // Half-up rounding: add half an LSB of the output scale, then drop FRAC_W bits.
  function automatic logic signed [SH_W-1:0] round_shift(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W:0] biased;
    biased = (ACC_W + 1)'(acc) + RND_BIAS;
    return biased[ACC_W:FRAC_W];
  endfunction

  function automatic logic sat_hit(input logic signed [SH_W-1:0] x);
    return x[SH_W-1:DATA_W-1] != {(SH_W - DATA_W + 1){x[SH_W-1]}};
  endfunction

  function automatic logic signed [DATA_W-1:0] clamp(input logic signed [SH_W-1:0] x);
    if (sat_hit(x)) begin
      return x[SH_W-1] ? {1'b1, {(DATA_W - 1){1'b0}}} : {1'b0, {(DATA_W - 1){1'b1}}};
    end
    return x[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/wn_cmult_round_sat.sv
// Three-stage complex multiply, round and saturate; every stage advances on en only.
// WN_ROTATOR_SAT_CNT_EN adds a per-sample saturation strobe for the parent's counter.
module wn_cmult_round_sat
  import wn_phase_compensation_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        en,
  input  logic        in_valid,
  input  logic [31:0] in_iq,
  input  logic [31:0] in_phase,
  input  logic        in_bypass,
  input  logic        in_last,
  input  logic        in_slot_last,
  output logic        out_valid,
  output logic [31:0] out_iq,
  output logic        out_last,
  output logic        out_slot_last
`ifdef WN_ROTATOR_SAT_CNT_EN
  ,
  output logic        sat_evt
`endif
);

  iq_sample_t  smp;
  phase_word_t ph;

  logic                     v1_q, v1_d, last1_q, last1_d, slot1_q, slot1_d;
  logic signed [PROD_W-1:0] p_ic_q, p_ic_d, p_qs_q, p_qs_d;
  logic signed [PROD_W-1:0] p_is_q, p_is_d, p_qc_q, p_qc_d;
  logic                     v2_q, v2_d, last2_q, last2_d, slot2_q, slot2_d;
  logic signed [ACC_W-1:0]  re_q, re_d, im_q, im_d;
  logic                     v3_q, v3_d, last3_q, last3_d, slot3_q, slot3_d;
  iq_sample_t               res_q, res_d;
  logic signed [SH_W-1:0]   sh_re, sh_im;

  assign smp   = iq_sample_t'(in_iq);
  assign ph    = phase_word_t'(in_phase);
  assign sh_re = round_shift(re_q);
  assign sh_im = round_shift(im_q);

  always_comb begin
    v1_d    = v1_q;    last1_d = last1_q; slot1_d = slot1_q;
    p_ic_d  = p_ic_q;  p_qs_d  = p_qs_q;  p_is_d  = p_is_q;  p_qc_d = p_qc_q;
    v2_d    = v2_q;    last2_d = last2_q; slot2_d = slot2_q;
    re_d    = re_q;    im_d    = im_q;
    v3_d    = v3_q;    last3_d = last3_q; slot3_d = slot3_q;
    res_d   = res_q;
    if (en) begin
      v1_d    = in_valid;
      last1_d = in_last;
      slot1_d = in_slot_last;
      if (in_bypass) begin
        // Pre-scaling by 2^FRAC_W makes the rounding stage hand I/Q back untouched.
        p_ic_d = PROD_W'(smp.i) <<< FRAC_W;
        p_qs_d = '0;
        p_is_d = '0;
        p_qc_d = PROD_W'(smp.q) <<< FRAC_W;
      end else begin
        p_ic_d = PROD_W'(smp.i) * PROD_W'(ph.cos);
        p_qs_d = PROD_W'(smp.q) * PROD_W'(ph.sin);
        p_is_d = PROD_W'(smp.i) * PROD_W'(ph.sin);
        p_qc_d = PROD_W'(smp.q) * PROD_W'(ph.cos);
      end
      v2_d    = v1_q;
      last2_d = last1_q;
      slot2_d = slot1_q;
      re_d    = ACC_W'(p_ic_q) - ACC_W'(p_qs_q);
      im_d    = ACC_W'(p_is_q) + ACC_W'(p_qc_q);
      v3_d    = v2_q;
      last3_d = last2_q;
      slot3_d = slot2_q;
      res_d.i = clamp(sh_re);
      res_d.q = clamp(sh_im);
    end
  end

`ifdef WN_ROTATOR_SAT_CNT_EN
  assign sat_evt = en && v2_q && (sat_hit(sh_re) || sat_hit(sh_im));
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      v1_q <= 1'b0; last1_q <= 1'b0; slot1_q <= 1'b0;
      p_ic_q <= '0; p_qs_q <= '0; p_is_q <= '0; p_qc_q <= '0;
      v2_q <= 1'b0; last2_q <= 1'b0; slot2_q <= 1'b0;
      re_q <= '0;   im_q <= '0;
      v3_q <= 1'b0; last3_q <= 1'b0; slot3_q <= 1'b0;
      res_q <= '0;
    end else begin
      v1_q <= v1_d; last1_q <= last1_d; slot1_q <= slot1_d;
      p_ic_q <= p_ic_d; p_qs_q <= p_qs_d; p_is_q <= p_is_d; p_qc_q <= p_qc_d;
      v2_q <= v2_d; last2_q <= last2_d; slot2_q <= slot2_d;
      re_q <= re_d; im_q <= im_d;
      v3_q <= v3_d; last3_q <= last3_d; slot3_q <= slot3_d;
      res_q <= res_d;
    end
  end

  assign out_valid     = v3_q;
  assign out_iq        = res_q;
  assign out_last      = last3_q;
  assign out_slot_last = slot3_q;

endmodule

// File: rtl/wn_phase_rotator.sv
// Per-symbol phase rotator: latches one phase word, rotates that symbol's samples.
// WN_ROTATOR_SAT_CNT_EN adds the sat_count port (saturated output samples, sticky at 0xFFFF).
//
//   state  | meaning
//   IDLE   | waiting for the next phase word; no samples accepted
//   ROTATE | phase latched; samples of one symbol flow until data tlast
module wn_phase_rotator
  import wn_phase_compensation_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        bypass_en,
  input  logic [31:0] phase_in_tdata,
  input  logic        phase_in_tvalid,
  output logic        phase_in_tready,
  input  logic        phase_in_tlast,
  input  logic [31:0] data_in_tdata,
  input  logic        data_in_tvalid,
  output logic        data_in_tready,
  input  logic        data_in_tlast,
  output logic [31:0] data_out_tdata,
  output logic        data_out_tvalid,
  input  logic        data_out_tready,
  output logic        data_out_tlast,
  output logic        data_out_slot_last
`ifdef WN_ROTATOR_SAT_CNT_EN
  ,
  output logic [15:0] sat_count
`endif
);

  rot_state_t  state_q, state_d;
  phase_word_t phase_q, phase_d;
  logic        slot_q, slot_d, byp_q, byp_d;
  logic        live_q, live_d;
  logic        pipe_en;

  assign pipe_en = !data_out_tvalid || data_out_tready;

  // live_q keeps phase_in_tready low for the first cycle out of reset.
  always_comb begin
    state_d         = state_q;
    phase_d         = phase_q;
    slot_d          = slot_q;
    byp_d           = byp_q;
    live_d          = 1'b1;
    phase_in_tready = 1'b0;
    data_in_tready  = 1'b0;
    unique case (state_q)
      IDLE: begin
        phase_in_tready = live_q;
        if (live_q && phase_in_tvalid) begin
          phase_d = phase_word_t'(phase_in_tdata);
          slot_d  = phase_in_tlast;
          byp_d   = bypass_en;
          state_d = ROTATE;
        end
      end
      ROTATE: begin
        data_in_tready = pipe_en;
        if (pipe_en && data_in_tvalid && data_in_tlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      phase_q <= '0;
      slot_q  <= 1'b0;
      byp_q   <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      slot_q  <= slot_d;
      byp_q   <= byp_d;
      live_q  <= live_d;
    end
  end

`ifdef WN_ROTATOR_SAT_CNT_EN
  logic        sat_evt;
  logic [15:0] sat_cnt_q, sat_cnt_d;

  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (sat_evt && (sat_cnt_q != 16'hFFFF)) sat_cnt_d = sat_cnt_q + 16'd1;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) sat_cnt_q <= '0;
    else          sat_cnt_q <= sat_cnt_d;
  end

  assign sat_count = sat_cnt_q;
`endif

  wn_cmult_round_sat u_dp (
    .clock         (clock),
    .reset_n       (reset_n),
    .en            (pipe_en),
    .in_valid      (data_in_tvalid && data_in_tready),
    .in_iq         (data_in_tdata),
    .in_phase      (phase_q),
    .in_bypass     (byp_q),
    .in_last       (data_in_tlast),
    .in_slot_last  (slot_q && data_in_tlast),
    .out_valid     (data_out_tvalid),
    .out_iq        (data_out_tdata),
    .out_last      (data_out_tlast),
    .out_slot_last (data_out_slot_last)
`ifdef WN_ROTATOR_SAT_CNT_EN
    ,
    .sat_evt       (sat_evt)
`endif
  );

endmodule

// File: tb/tb_wn_phase_rotator.sv
// Scoreboard bench for wn_phase_rotator: driver pushes model results, monitor pops on output handshakes.
module tb_wn_phase_rotator;

  logic        clock = 1'b0;
  logic        reset_n, bypass_en;
  logic [31:0] phase_in_tdata;
  logic        phase_in_tvalid, phase_in_tready, phase_in_tlast;
  logic [31:0] data_in_tdata;
  logic        data_in_tvalid, data_in_tready, data_in_tlast;
  logic [31:0] data_out_tdata;
  logic        data_out_tvalid, data_out_tready, data_out_tlast, data_out_slot_last;
`ifdef WN_ROTATOR_SAT_CNT_EN
  logic [15:0] sat_count;
`endif

  always #5 clock = ~clock;

  wn_phase_rotator dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .bypass_en          (bypass_en),
    .phase_in_tdata     (phase_in_tdata),
    .phase_in_tvalid    (phase_in_tvalid),
    .phase_in_tready    (phase_in_tready),
    .phase_in_tlast     (phase_in_tlast),
    .data_in_tdata      (data_in_tdata),
    .data_in_tvalid     (data_in_tvalid),
    .data_in_tready     (data_in_tready),
    .data_in_tlast      (data_in_tlast),
    .data_out_tdata     (data_out_tdata),
    .data_out_tvalid    (data_out_tvalid),
    .data_out_tready    (data_out_tready),
    .data_out_tlast     (data_out_tlast),
    .data_out_slot_last (data_out_slot_last)
`ifdef WN_ROTATOR_SAT_CNT_EN
    ,
    .sat_count          (sat_count)
`endif
  );

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          sat_exp = 0;
  int          tready_mode = 0;
  int          lat_ref = -1;
  bit          lat_arm = 0;
  int          si[64];
  int          sq[64];
  logic [33:0] exp_q[$];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Reference: exact integer rotation, floor((x + 2^14) / 2^15), clamp to int16.
  function automatic longint round_q15(input longint acc);
    return (acc + 64'sd16384) >>> 15;
  endfunction

  function automatic int clamp16(input longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  task automatic push_exp(input int i, input int q, input int c, input int s,
                          input bit byp, input bit last, input bit slot);
    longint re, im, rr, ri;
    int     oi, oq;
    if (byp) begin
      oi = i; oq = q;
    end else begin
      re = longint'(i) * c - longint'(q) * s;
      im = longint'(i) * s + longint'(q) * c;
      rr = round_q15(re);
      ri = round_q15(im);
      oi = clamp16(rr);
      oq = clamp16(ri);
      if ((longint'(oi) != rr) || (longint'(oq) != ri)) begin
        if (sat_exp < 65535) sat_exp++;
      end
    end
    exp_q.push_back({16'(oq), 16'(oi), last, slot});
  endtask

  initial begin
    data_out_tready = 1'b0;
    forever begin
      @(posedge clock); #1;
      case (tready_mode)
        0:       data_out_tready = 1'b1;
        1:       data_out_tready = ((cyc / 3) % 2) == 0;
        2:       data_out_tready = 1'b0;
        default: data_out_tready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  logic [32:0] stall_val;
  bit          stall_seen = 0;
  logic [33:0] e;

  always @(negedge clock) begin
    if (!reset_n) begin
      stall_seen = 0;
    end else begin
      if (stall_seen)
        chk("stall_hold", {data_out_tvalid, data_out_tdata, data_out_tlast}, {1'b1, stall_val});
      stall_seen = data_out_tvalid && !data_out_tready;
      stall_val  = {data_out_tdata, data_out_tlast};
      if (data_out_tvalid && data_out_tready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", {data_out_tdata, data_out_tlast, data_out_slot_last}, 0);
        end else begin
          e = exp_q.pop_front();
          chk("out_sample", {data_out_tdata, data_out_tlast, data_out_slot_last}, e);
        end
        if (lat_ref >= 0) begin
          chk("first_latency", 64'(cyc - lat_ref), 64'd3);
          lat_ref = -1;
        end
      end
    end
  end

  task automatic send_symbol(input int c, input int s, input bit plast, input bit byp,
                             input int n, input int n_send, input bit gaps);
    int k;
    phase_in_tdata  = {16'(s), 16'(c)};
    phase_in_tlast  = plast;
    bypass_en       = byp;
    phase_in_tvalid = 1'b1;
    k = 0;
    while (1) begin
      @(negedge clock);
      if (phase_in_tready) break;
      if (++k > 300) begin
        chk("phase_accept_timeout", 64'(k), 0);
        phase_in_tvalid = 1'b0;
        return;
      end
    end
    @(posedge clock); #1;
    phase_in_tvalid = 1'b0;
    phase_in_tdata  = $urandom;
    phase_in_tlast  = ~plast;
    bypass_en       = ~byp;
    for (int j = 0; j < n_send; j++) begin
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin @(posedge clock); #1; end
      end
      data_in_tdata  = {16'(sq[j]), 16'(si[j])};
      data_in_tlast  = (j == n - 1);
      data_in_tvalid = 1'b1;
      k = 0;
      while (1) begin
        @(negedge clock);
        if (data_in_tready) break;
        if (++k > 300) begin
          chk("data_accept_timeout", 64'(k), 0);
          data_in_tvalid = 1'b0;
          return;
        end
      end
      chk("phase_ready_in_symbol", 64'(phase_in_tready), 0);
      push_exp(si[j], sq[j], c, s, byp, j == n - 1, plast && (j == n - 1));
      if (lat_arm && j == 0) begin
        lat_ref = cyc;
        lat_arm = 0;
      end
      @(posedge clock); #1;
      data_in_tvalid = 1'b0;
      data_in_tlast  = 1'b0;
    end
  endtask

  task automatic wait_drain(input string nm);
    int k = 0;
    while (exp_q.size() != 0 && k < 2000) begin @(negedge clock); k++; end
    chk({nm, "_drained"}, 64'(exp_q.size()), 0);
    exp_q.delete();
    repeat (2) @(negedge clock);
`ifdef WN_ROTATOR_SAT_CNT_EN
    chk({nm, "_sat_count"}, 64'(sat_count), 64'(sat_exp));
`endif
    @(posedge clock); #1;
  endtask

  initial begin
    reset_n = 1'b0; bypass_en = 1'b0;
    phase_in_tdata = '0; phase_in_tvalid = 1'b0; phase_in_tlast = 1'b0;
    data_in_tdata = '0;  data_in_tvalid = 1'b0;  data_in_tlast = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_outputs", {phase_in_tready, data_in_tready, data_out_tdata,
                          data_out_tvalid, data_out_tlast, data_out_slot_last}, 0);
    @(posedge clock); #1;
    reset_n = 1'b1;

    // Unit phase, fixed I/Q, latency check on the first sample
    tready_mode = 0;
    for (int j = 0; j < 4; j++) begin si[j] = 1000; sq[j] = -2000; end
    repeat (2) @(posedge clock); #1;
    lat_arm = 1;
    send_symbol(32767, 0, 1'b0, 1'b0, 4, 4, 1'b0);
    wait_drain("unit_phase");

    send_symbol(0, 32767, 1'b0, 1'b0, 4, 4, 1'b0);
    wait_drain("quarter_turn");

    si[0] = -32768; sq[0] = -32768;
    send_symbol(-32768, -32768, 1'b0, 1'b0, 1, 1, 1'b0);
    wait_drain("saturate");

    // Two symbols under periodic backpressure, slot end on the second
    tready_mode = 1;
    for (int j = 0; j < 8; j++) begin
      si[j] = int'($urandom_range(0, 65535)) - 32768;
      sq[j] = int'($urandom_range(0, 65535)) - 32768;
    end
    send_symbol(23170, 23170, 1'b0, 1'b0, 8, 8, 1'b0);
    for (int j = 0; j < 8; j++) begin
      si[j] = int'($urandom_range(0, 65535)) - 32768;
      sq[j] = int'($urandom_range(0, 65535)) - 32768;
    end
    send_symbol(-12000, 28000, 1'b1, 1'b0, 8, 8, 1'b0);
    wait_drain("two_symbols");

    // Bypass: bit-exact at the same latency
    tready_mode = 0;
    for (int j = 0; j < 16; j++) begin
      si[j] = int'($urandom_range(0, 65535)) - 32768;
      sq[j] = int'($urandom_range(0, 65535)) - 32768;
    end
    lat_arm = 1;
    send_symbol(1234, -4321, 1'b1, 1'b1, 16, 16, 1'b0);
    wait_drain("bypass");

    // Randomized symbols with input gaps and random backpressure
    tready_mode = 3;
    for (int r = 0; r < 10; r++) begin
      int n, c, s;
      n = int'($urandom_range(1, 12));
      c = int'($urandom_range(0, 65535)) - 32768;
      s = int'($urandom_range(0, 65535)) - 32768;
      if ($urandom_range(0, 3) == 0) c = -32768;
      for (int j = 0; j < n; j++) begin
        si[j] = int'($urandom_range(0, 65535)) - 32768;
        sq[j] = int'($urandom_range(0, 65535)) - 32768;
      end
      send_symbol(c, s, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), n, n, 1'b1);
    end
    wait_drain("random");

    // Reset in the middle of a stalled symbol
    tready_mode = 2;
    @(posedge clock); #1;
    for (int j = 0; j < 8; j++) begin si[j] = 500 + j; sq[j] = -700 - j; end
    send_symbol(20000, -9000, 1'b1, 1'b0, 8, 3, 1'b0);
    reset_n = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    exp_q.delete();
    sat_exp = 0;
    @(negedge clock);
    chk("reset_mid_outputs", {phase_in_tready, data_in_tready, data_out_tdata,
                              data_out_tvalid, data_out_tlast, data_out_slot_last}, 0);
`ifdef WN_ROTATOR_SAT_CNT_EN
    chk("reset_mid_sat_count", 64'(sat_count), 0);
`endif
    tready_mode = 0;
    @(posedge clock); #1;
    data_in_tvalid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("no_data_without_phase", 64'(data_in_tready), 0);
    end
    @(posedge clock); #1;
    data_in_tvalid = 1'b0;
    for (int j = 0; j < 4; j++) begin si[j] = -3000 + 17 * j; sq[j] = 4000 - 9 * j; end
    send_symbol(30000, 12000, 1'b0, 1'b0, 4, 4, 1'b0);
    wait_drain("after_reset");

    repeat (5) @(posedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wn_phase_rotator.md
Name: wn_phase_rotator

Overview:
Complex-multiply stage that applies per-symbol phase compensation to the IQ sample stream.
- Sits directly downstream of the phase parameter generator; consumes one phase word per OFDM symbol.
- Rotates every sample of that symbol: out = in × (cos + j·sin).
- Output is the compensated AXI-Stream that leaves the phase compensation top.

Parameters:
- DATA_W, 16, width of each I/Q component and each cos/sin component, signed.
- FRAC_W, 15, fractional bits of cos/sin (Q1.15); products are shifted right by FRAC_W.

Ports:
- clock  in  1  single clock
- reset_n  in  1  synchronous, active-low reset
- bypass_en  in  1  quasi-static; sampled when a phase word is accepted
- phase_in_tdata  in  32  [15:0] cos, [31:16] sin, signed Q1.15
- phase_in_tvalid  in  1  phase word valid
- phase_in_tready  out  1  phase word accepted
- phase_in_tlast  in  1  last symbol of slot
- data_in_tdata  in  32  [15:0] I, [31:16] Q, signed
- data_in_tvalid  in  1  sample valid
- data_in_tready  out  1  sample accepted
- data_in_tlast  in  1  last sample of symbol
- data_out_tdata  out  32  [15:0] I, [31:16] Q, rotated
- data_out_tvalid  out  1  output valid
- data_out_tready  in  1  downstream ready
- data_out_tlast  out  1  last sample of symbol
- data_out_slot_last  out  1  asserted with data_out_tlast of the slot's final symbol

Behaviour:
- Reset (reset_n=0 at posedge): FSM→IDLE; all pipeline valids cleared; in-flight samples discarded.
  - All outputs 0: phase_in_tready, data_in_tready, data_out_tdata, data_out_tvalid, data_out_tlast, data_out_slot_last.
  - Phase register cleared.
  - Reset mid-symbol: remainder of that symbol is not emitted; the next accepted phase starts a fresh symbol.
- FSM:
  - IDLE: phase_in_tready=1, data_in_tready=0. On phase handshake, latch cos, sin, phase_in_tlast and bypass_en, then →ROTATE.
  - ROTATE: phase_in_tready=0; data_in_tready=pipe_en. On a data handshake with data_in_tlast=1, →IDLE in the next cycle.
  - Each phase word applies to exactly one symbol. Samples are never accepted without a latched phase.
- Pipeline: 3 stages, stall-all.
  - pipe_en = !v3 || data_out_tready.
  - All stages advance only when pipe_en=1.
  - S1 registers four 32-bit signed products: I·c, Q·s, I·s, Q·c.
  - S2 computes 33-bit sums: re = I·c − Q·s, im = I·s + Q·c.
  - S3 rounds, saturates and drives the outputs.
  - Latency from data handshake to data_out_tvalid is 3 cycles when not stalled. Throughput is 1 sample/cycle.
  - tlast and slot_last (latched phase tlast AND data tlast) travel alongside the data.
- Rounding and saturation:
  - Round half-up: add 2^(FRAC_W−1), then arithmetic shift right by FRAC_W.
  - Saturate to [−32768, 32767] per component.
- Bypass: when the latched bypass_en=1, S1 carries I/Q unchanged through the same 3-stage latency. Output is bit-exact with the input.
- Stall: while data_out_tvalid=1 and data_out_tready=0, data_out_tdata/tlast stay stable. No sample is lost or duplicated.
- Phase and symbol boundary in the same cycle: the next phase is not accepted until the FSM is back in IDLE, one cycle after the tlast handshake. This gives a 1-cycle bubble per symbol on the input side only; the output pipeline keeps draining.
- A phase arriving during ROTATE is held by upstream, because tready=0.

Optional Feature:
- Macro: WN_ROTATOR_SAT_CNT_EN.
- Defined:
  - Adds output port sat_count [15:0].
  - Counts output samples where either component saturated.
  - The counter sticks at 0xFFFF and is cleared by reset.
- Undefined: port and logic absent; saturation is silent.

Decomposition:
- Shared package wn_phase_compensation_pkg holds:
  - typedef iq_sample_t {logic signed [15:0] q; logic signed [15:0] i;}
  - typedef phase_word_t {logic signed [15:0] sin; logic signed [15:0] cos;}
  - constants ROT_LATENCY=3, Q15_ONE=16'sh7FFF
  - the FSM state enum {IDLE, ROTATE}
- One sub-module: wn_cmult_round_sat, the 3-stage complex multiply, round and saturate datapath with an enable input. The FSM and handshakes stay in the parent.

Test Plan:
- Phase (cos=32767, sin=0), 4-sample symbol with I=1000, Q=−2000 → each output I=1000, Q=−2000; first valid 3 cycles after the first accept; tlast on the 4th sample.
- Phase (cos=0, sin=32767), I=1000, Q=−2000 → output I=2000, Q=1000.
- Phase (cos=−32768, sin=−32768), I=Q=−32768 → output I=0, Q=32767 (saturated); sat_count=1 when WN_ROTATOR_SAT_CNT_EN is defined.
- Two phases, 8-sample symbols, second phase tlast=1, data_out_tready toggled 1/0 every 3 cycles → 16 outputs in order, no duplicates; slot_last only on output 16; phase_in_tready low during each symbol.
- bypass_en=1, random I/Q, 16 samples → output bit-exact with input at 3-cycle latency.
- reset_n pulsed low for 1 cycle after the 3rd of 8 samples → all outputs 0 next cycle; FSM in IDLE; a new phase plus a 4-sample symbol then produces exactly 4 correct outputs.
